// File: rtl/irq_gen_mc_if.sv
// -----------------------------------------------------------------------------
// irq_gen_mc_if
// Signal bundle between an error-source/register block and irq_gen_mc.
//   error_i   per-channel error event strobes
//   mask_i    per-channel interrupt mask (1 = masked)
//   clear_i   per-channel write-1-to-clear pulses for status_o
//   status_o  sticky per-channel error cause
//   irq_ch_o  per-channel interrupt lines
//   irq_o     combined interrupt line
//   err_cnt_o per-channel 8-bit saturating error counts
//             (only with IRQ_GEN_MC_ERR_CNT_EN defined)
// Modports: master = side that drives the events, slave = irq_gen_mc.
// -----------------------------------------------------------------------------
interface irq_gen_mc_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0]   error_i;
  logic [N_CH-1:0]   mask_i;
  logic [N_CH-1:0]   clear_i;
  logic [N_CH-1:0]   status_o;
  logic [N_CH-1:0]   irq_ch_o;
  logic              irq_o;
`ifdef IRQ_GEN_MC_ERR_CNT_EN
  logic [N_CH*8-1:0] err_cnt_o;

  modport master (output error_i, mask_i, clear_i,
                  input  status_o, irq_ch_o, irq_o, err_cnt_o);
  modport slave  (input  error_i, mask_i, clear_i,
                  output status_o, irq_ch_o, irq_o, err_cnt_o);
`else
  modport master (output error_i, mask_i, clear_i,
                  input  status_o, irq_ch_o, irq_o);
  modport slave  (input  error_i, mask_i, clear_i,
                  output status_o, irq_ch_o, irq_o);
`endif
endinterface

// File: rtl/irq_gen_mc.sv
// -----------------------------------------------------------------------------
// irq_gen_mc
// Multi-channel interrupt generator for the register-station error path.
// Each channel keeps a sticky status bit (set by error_i, cleared by clear_i,
// set wins) and drives a registered interrupt line:
//   IRQ_MODE 0 (HOLD)  : an unmasked event starts a pulse of IRQ_HOLD_TIME
//                        cycles; RETRIGGER selects whether events during a
//                        pulse reload it. The mask gates the output only.
//   IRQ_MODE 1 (LEVEL) : interrupt follows next status & ~mask.
// irq_o is the OR of all per-channel lines.
// The block is only built when ERR_RESP_EN && IRQ_EN; otherwise every output
// is tied low and no flops exist.
//
// Ports
//   aclk  clock, all logic on posedge
//   rst   synchronous reset, active-high
//   bus   irq_gen_mc_if.slave (error_i, mask_i, clear_i in;
//         status_o, irq_ch_o, irq_o [, err_cnt_o] out)
//
// Optional feature: define IRQ_GEN_MC_ERR_CNT_EN to add err_cnt_o, an 8-bit
// saturating per-channel count of cycles with error_i high (mask-agnostic,
// zeroed by clear_i, becomes 1 when clear and error coincide).
// -----------------------------------------------------------------------------
module irq_gen_mc #(
  parameter bit ERR_RESP_EN   = 1'b0,
  parameter bit IRQ_EN        = 1'b0,
  parameter int N_CH          = 4,
  parameter int IRQ_MODE      = 0,
  parameter int IRQ_HOLD_TIME = 1024,
  parameter bit RETRIGGER     = 1'b0
) (
  input  logic         aclk,
  input  logic         rst,
  irq_gen_mc_if.slave  bus
);

  localparam bit BLOCK_EN = ERR_RESP_EN && IRQ_EN;
  localparam int CNT_W    = $clog2(IRQ_HOLD_TIME + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } hold_state_e;

  if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
    $error("irq_gen_mc: N_CH must be in 1..32");
  end
  if (IRQ_HOLD_TIME < 1) begin : g_bad_hold
    $error("irq_gen_mc: IRQ_HOLD_TIME must be >= 1");
  end
  if (IRQ_MODE > 1 || IRQ_MODE < 0) begin : g_bad_mode
    $error("irq_gen_mc: IRQ_MODE must be 0 or 1");
  end

  if (BLOCK_EN) begin : g_on
    logic [N_CH-1:0] status_q;
    logic [N_CH-1:0] status_d;
    logic [N_CH-1:0] irq_ch_q;

    // NOTE: always_comb with a single unconditional assignment covers every
    // path; a branch that left status_d unassigned would infer a latch.
    always_comb begin
      status_d = (status_q & ~bus.clear_i) | bus.error_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge aclk) begin
      if (rst) begin
        status_q <= '0;
      end else begin
        status_q <= status_d;
      end
    end

    if (IRQ_MODE == 0) begin : g_hold
      localparam logic [CNT_W-1:0] RELOAD = CNT_W'(IRQ_HOLD_TIME - 1);

      hold_state_e      state_q [N_CH];
      logic [CNT_W-1:0] cnt_q   [N_CH];
      logic [N_CH-1:0]  trig;

      // Only unmasked events start or reload a pulse.
      assign trig = bus.error_i & ~bus.mask_i;

      always_ff @(posedge aclk) begin
        if (rst) begin
          // NOTE: these per-channel arrays are small flop banks, not RAM,
          // so resetting them is cheap and keeps the pulse state defined.
          for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
          end
          irq_ch_q <= '0;
        end else begin
          for (int i = 0; i < N_CH; i++) begin
            unique case (state_q[i])
              IDLE: begin
                if (trig[i]) begin
                  state_q[i]  <= ACTIVE;
                  cnt_q[i]    <= RELOAD;
                  irq_ch_q[i] <= 1'b1;
                end else begin
                  irq_ch_q[i] <= 1'b0;
                end
              end
              ACTIVE: begin
                // Reload beats expiry, so a retrigger on the last cycle
                // extends the pulse seamlessly.
                if (RETRIGGER && trig[i]) begin
                  cnt_q[i]    <= RELOAD;
                  irq_ch_q[i] <= 1'b1;
                end else if (cnt_q[i] == '0) begin
                  state_q[i]  <= IDLE;
                  irq_ch_q[i] <= 1'b0;
                end else begin
                  // Counter keeps running while masked; mask only gates.
                  cnt_q[i]    <= cnt_q[i] - 1'b1;
                  irq_ch_q[i] <= ~bus.mask_i[i];
                end
              end
            endcase
          end
        end
      end
    end else begin : g_level
      always_ff @(posedge aclk) begin
        if (rst) begin
          irq_ch_q <= '0;
        end else begin
          irq_ch_q <= status_d & ~bus.mask_i;
        end
      end
    end

    assign bus.status_o = status_q;
    assign bus.irq_ch_o = irq_ch_q;
    assign bus.irq_o    = |irq_ch_q;

`ifdef IRQ_GEN_MC_ERR_CNT_EN
    logic [7:0] err_cnt_q [N_CH];

    always_ff @(posedge aclk) begin
      if (rst) begin
        for (int i = 0; i < N_CH; i++) begin
          err_cnt_q[i] <= 8'd0;
        end
      end else begin
        for (int i = 0; i < N_CH; i++) begin
          if (bus.clear_i[i]) begin
            err_cnt_q[i] <= {7'd0, bus.error_i[i]};
          end else if (bus.error_i[i] && (err_cnt_q[i] != 8'hFF)) begin
            err_cnt_q[i] <= err_cnt_q[i] + 8'd1;
          end
        end
      end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
      assign bus.err_cnt_o[g*8 +: 8] = err_cnt_q[g];
    end
`endif
  end else begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{bus.error_i, bus.mask_i, bus.clear_i, aclk, rst};

    assign bus.status_o = '0;
    assign bus.irq_ch_o = '0;
    assign bus.irq_o    = 1'b0;
`ifdef IRQ_GEN_MC_ERR_CNT_EN
    assign bus.err_cnt_o = '0;
`endif
  end

endmodule

// File: tb/tb_irq_gen_mc.sv
// -----------------------------------------------------------------------------
// tb_irq_gen_mc
// Seven irq_gen_mc instances share one stimulus stream:
//   0: HOLD T=4  R=0    1: HOLD T=8  R=0    2: HOLD T=8 R=1
//   3: LEVEL            4: HOLD T=1  R=0    5: HOLD T=16 R=0
//   6: disabled build (ERR_RESP_EN=0)
// A reference model tracks remaining pulse length per channel and sticky
// status; every cycle after reset all instance outputs are compared with it.
// Directed sections add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_irq_gen_mc;

  localparam int NI = 7;

  logic       aclk = 1'b0;
  logic       rst  = 1'b1;
  logic [3:0] err  = 4'h0;
  logic [3:0] msk  = 4'h0;
  logic [3:0] clr  = 4'h0;

  always #5 aclk = ~aclk;

  irq_gen_mc_if #(.N_CH(4)) if_a ();
  irq_gen_mc_if #(.N_CH(4)) if_b ();
  irq_gen_mc_if #(.N_CH(4)) if_c ();
  irq_gen_mc_if #(.N_CH(4)) if_d ();
  irq_gen_mc_if #(.N_CH(4)) if_e ();
  irq_gen_mc_if #(.N_CH(4)) if_g ();
  irq_gen_mc_if #(.N_CH(4)) if_f ();

  assign if_a.error_i = err; assign if_a.mask_i = msk; assign if_a.clear_i = clr;
  assign if_b.error_i = err; assign if_b.mask_i = msk; assign if_b.clear_i = clr;
  assign if_c.error_i = err; assign if_c.mask_i = msk; assign if_c.clear_i = clr;
  assign if_d.error_i = err; assign if_d.mask_i = msk; assign if_d.clear_i = clr;
  assign if_e.error_i = err; assign if_e.mask_i = msk; assign if_e.clear_i = clr;
  assign if_g.error_i = err; assign if_g.mask_i = msk; assign if_g.clear_i = clr;
  assign if_f.error_i = err; assign if_f.mask_i = msk; assign if_f.clear_i = clr;

  irq_gen_mc #(.ERR_RESP_EN(1'b1), .IRQ_EN(1'b1), .N_CH(4), .IRQ_MODE(0),
               .IRQ_HOLD_TIME(4), .RETRIGGER(1'b0))
    u_a (.aclk(aclk), .rst(rst), .bus(if_a));
  irq_gen_mc #(.ERR_RESP_EN(1'b1), .IRQ_EN(1'b1), .N_CH(4), .IRQ_MODE(0),
               .IRQ_HOLD_TIME(8), .RETRIGGER(1'b0))
    u_b (.aclk(aclk), .rst(rst), .bus(if_b));
  irq_gen_mc #(.ERR_RESP_EN(1'b1), .IRQ_EN(1'b1), .N_CH(4), .IRQ_MODE(0),
               .IRQ_HOLD_TIME(8), .RETRIGGER(1'b1))
    u_c (.aclk(aclk), .rst(rst), .bus(if_c));
  irq_gen_mc #(.ERR_RESP_EN(1'b1), .IRQ_EN(1'b1), .N_CH(4), .IRQ_MODE(1),
               .IRQ_HOLD_TIME(4), .RETRIGGER(1'b0))
    u_d (.aclk(aclk), .rst(rst), .bus(if_d));
  irq_gen_mc #(.ERR_RESP_EN(1'b1), .IRQ_EN(1'b1), .N_CH(4), .IRQ_MODE(0),
               .IRQ_HOLD_TIME(1), .RETRIGGER(1'b0))
    u_e (.aclk(aclk), .rst(rst), .bus(if_e));
  irq_gen_mc #(.ERR_RESP_EN(1'b1), .IRQ_EN(1'b1), .N_CH(4), .IRQ_MODE(0),
               .IRQ_HOLD_TIME(16), .RETRIGGER(1'b0))
    u_g (.aclk(aclk), .rst(rst), .bus(if_g));
  irq_gen_mc #(.ERR_RESP_EN(1'b0), .IRQ_EN(1'b1), .N_CH(4), .IRQ_MODE(0),
               .IRQ_HOLD_TIME(4), .RETRIGGER(1'b0))
    u_f (.aclk(aclk), .rst(rst), .bus(if_f));

  logic [3:0] d_st  [NI];
  logic [3:0] d_irq [NI];
  logic       d_irqo[NI];

  assign d_st[0] = if_a.status_o; assign d_irq[0] = if_a.irq_ch_o; assign d_irqo[0] = if_a.irq_o;
  assign d_st[1] = if_b.status_o; assign d_irq[1] = if_b.irq_ch_o; assign d_irqo[1] = if_b.irq_o;
  assign d_st[2] = if_c.status_o; assign d_irq[2] = if_c.irq_ch_o; assign d_irqo[2] = if_c.irq_o;
  assign d_st[3] = if_d.status_o; assign d_irq[3] = if_d.irq_ch_o; assign d_irqo[3] = if_d.irq_o;
  assign d_st[4] = if_e.status_o; assign d_irq[4] = if_e.irq_ch_o; assign d_irqo[4] = if_e.irq_o;
  assign d_st[5] = if_g.status_o; assign d_irq[5] = if_g.irq_ch_o; assign d_irqo[5] = if_g.irq_o;
  assign d_st[6] = if_f.status_o; assign d_irq[6] = if_f.irq_ch_o; assign d_irqo[6] = if_f.irq_o;

`ifdef IRQ_GEN_MC_ERR_CNT_EN
  logic [31:0] d_cnt [NI];
  assign d_cnt[0] = if_a.err_cnt_o; assign d_cnt[1] = if_b.err_cnt_o;
  assign d_cnt[2] = if_c.err_cnt_o; assign d_cnt[3] = if_d.err_cnt_o;
  assign d_cnt[4] = if_e.err_cnt_o; assign d_cnt[5] = if_g.err_cnt_o;
  assign d_cnt[6] = if_f.err_cnt_o;
`endif

  // Per-instance configuration seen by the model.
  int hold_t [NI] = '{4, 8, 8, 0, 1, 16, 0};
  bit retrig [NI] = '{0, 0, 1, 0, 0, 0, 0};
  bit level  [NI] = '{0, 0, 0, 1, 0, 0, 0};

  // Model state: cycles of pulse still to be shown, sticky status, outputs.
  int         rem_m [NI][4];
  logic [3:0] st_m  [NI];
  logic [3:0] irq_m [NI];
  logic [7:0] cnt_m [NI][4];

  bit cmp_en = 1'b0;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step();
    for (int k = 0; k < NI; k++) begin
      if (rst || k == NI - 1) begin
        st_m[k]  = 4'h0;
        irq_m[k] = 4'h0;
        for (int c = 0; c < 4; c++) begin
          rem_m[k][c] = 0;
          cnt_m[k][c] = 8'd0;
        end
      end else begin
        for (int c = 0; c < 4; c++) begin
          if (clr[c])                           cnt_m[k][c] = {7'd0, err[c]};
          else if (err[c] && cnt_m[k][c] < 255) cnt_m[k][c] = cnt_m[k][c] + 8'd1;
        end
        st_m[k] = (st_m[k] & ~clr) | err;
        if (level[k]) begin
          irq_m[k] = st_m[k] & ~msk;
        end else begin
          for (int c = 0; c < 4; c++) begin
            bit trig;
            trig = err[c] && !msk[c];
            if (rem_m[k][c] == 0) begin
              if (trig) rem_m[k][c] = hold_t[k];
            end else if (retrig[k] && trig) begin
              rem_m[k][c] = hold_t[k];
            end else begin
              rem_m[k][c] = rem_m[k][c] - 1;
            end
            irq_m[k][c] = (rem_m[k][c] > 0) && !msk[c];
          end
        end
      end
    end
  endfunction

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("status[%0d]", k), d_st[k],  st_m[k]);
      check($sformatf("irq_ch[%0d]", k), d_irq[k], irq_m[k]);
      check($sformatf("irq_o[%0d]", k),  d_irqo[k], |irq_m[k]);
`ifdef IRQ_GEN_MC_ERR_CNT_EN
      begin
        logic [31:0] exp_cnt;
        for (int c = 0; c < 4; c++) exp_cnt[c*8 +: 8] = cnt_m[k][c];
        check($sformatf("err_cnt[%0d]", k), d_cnt[k], exp_cnt);
      end
`endif
    end
  endtask

  always @(posedge aclk) begin
    model_step();
    #1;
    if (cmp_en) compare_all();
  end

  // Inputs change on the falling edge; the next rising edge samples them.
  task automatic step(input logic [3:0] e, input logic [3:0] m,
                      input logic [3:0] c, input logic r = 1'b0);
    @(negedge aclk);
    err = e;
    msk = m;
    clr = c;
    rst = r;
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'h0, 4'h0, 4'h0);
  endtask

  initial begin
    // Reset state (rst has been high across the first rising edge).
    step(4'h0, 4'h0, 4'h0, 1'b1);
    cmp_en = 1'b1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_status[%0d]", k), d_st[k], 4'h0);
      check($sformatf("rst_irq[%0d]", k),    d_irq[k], 4'h0);
      check($sformatf("rst_irqo[%0d]", k),   d_irqo[k], 1'b0);
    end
    idle(2);

    // HOLD T=4: single event on ch0 -> four cycles of irq, sticky status.
    step(4'b0001, 4'h0, 4'h0);
    for (int j = 1; j <= 5; j++) begin
      step(4'h0, 4'h0, 4'h0);
      check($sformatf("t1_irq_ch_c%0d", j), d_irq[0], (j <= 4) ? 4'b0001 : 4'b0000);
      check($sformatf("t1_irq_o_c%0d", j),  d_irqo[0], j <= 4);
    end
    check("t1_status_held", d_st[0], 4'b0001);
    step(4'h0, 4'h0, 4'b0001);
    step(4'h0, 4'h0, 4'h0);
    check("t1_status_cleared", d_st[0], 4'b0000);
    idle(20);

    // Second event on ch2 three cycles after the first; T=8, R=0 vs R=1.
    for (int j = 0; j <= 12; j++) begin
      step((j == 0 || j == 3) ? 4'b0100 : 4'b0000, 4'h0, 4'h0);
      if (j == 1)  check("t2_t1_pulse_on",   d_irq[4][2], 1'b1);
      if (j == 2)  check("t2_t1_pulse_off",  d_irq[4][2], 1'b0);
      if (j == 8)  check("t2_r0_last",       d_irq[1][2], 1'b1);
      if (j == 9)  check("t2_r0_ended",      d_irq[1][2], 1'b0);
      if (j == 11) check("t2_r1_last",       d_irq[2][2], 1'b1);
      if (j == 12) check("t2_r1_ended",      d_irq[2][2], 1'b0);
    end
    step(4'h0, 4'h0, 4'hF);
    idle(20);

    // Masked event: status records, no interrupt.
    step(4'b0010, 4'b0010, 4'h0);
    step(4'h0, 4'b0010, 4'h0);
    check("t3_masked_irq_ch", d_irq[0][1], 1'b0);
    check("t3_masked_irq_o",  d_irqo[0], 1'b0);
    check("t3_masked_status", d_st[0][1], 1'b1);
    step(4'h0, 4'h0, 4'b0010);
    idle(20);

    // Pulse on ch1 (T=8) masked for three edges mid-pulse, then unmasked.
    for (int j = 0; j <= 10; j++) begin
      step((j == 0) ? 4'b0010 : 4'b0000,
           (j >= 2 && j <= 4) ? 4'b0010 : 4'b0000, 4'h0);
      if (j == 2) check("t3_pre_mask",     d_irq[1][1], 1'b1);
      if (j == 3) check("t3_masked",       d_irq[1][1], 1'b0);
      if (j == 5) check("t3_still_masked", d_irq[1][1], 1'b0);
      if (j == 6) check("t3_unmasked",     d_irq[1][1], 1'b1);
      if (j == 8) check("t3_remaining",    d_irq[1][1], 1'b1);
      if (j == 9) check("t3_done",         d_irq[1][1], 1'b0);
    end
    step(4'h0, 4'h0, 4'b0010);
    idle(20);

    // LEVEL mode on ch3.
    step(4'b1000, 4'h0, 4'h0);
    step(4'h0, 4'h0, 4'h0);
    check("t4_level_rise", d_irq[3], 4'b1000);
    step(4'h0, 4'h0, 4'b1000);
    step(4'h0, 4'h0, 4'h0);
    check("t4_level_clear", d_irq[3], 4'b0000);
    check("t4_status_clear", d_st[3], 4'b0000);
    step(4'b1000, 4'h0, 4'h0);
    step(4'b1000, 4'h0, 4'b1000);
    step(4'h0, 4'h0, 4'h0);
    check("t4_set_wins_irq",    d_irq[3][3], 1'b1);
    check("t4_set_wins_status", d_st[3][3], 1'b1);
    step(4'h0, 4'b1000, 4'h0);
    step(4'h0, 4'h0, 4'h0);
    check("t4_level_masked", d_irq[3][3], 1'b0);
    step(4'h0, 4'h0, 4'h0);
    check("t4_level_unmasked", d_irq[3][3], 1'b1);
    step(4'h0, 4'h0, 4'hF);
    idle(20);

    // All channels in the same cycle.
    step(4'b1111, 4'h0, 4'h0);
    step(4'h0, 4'h0, 4'h0);
    check("t_all_ch", d_irq[0], 4'b1111);
    step(4'h0, 4'h0, 4'hF);
    idle(20);

    // Reset two cycles into a T=16 pulse.
    for (int j = 0; j <= 8; j++) begin
      step((j == 0) ? 4'b0001 : 4'b0000, 4'h0, 4'h0, (j == 2));
      if (j == 2) check("t5_pulse_before_rst", d_irq[5], 4'b0001);
      if (j == 3) begin
        for (int k = 0; k < NI; k++) begin
          check($sformatf("t5_rst_irq[%0d]", k),    d_irq[k], 4'h0);
          check($sformatf("t5_rst_status[%0d]", k), d_st[k], 4'h0);
          check($sformatf("t5_rst_irqo[%0d]", k),   d_irqo[k], 1'b0);
        end
      end
      if (j > 3) check($sformatf("t5_no_residual_c%0d", j), d_irq[5], 4'h0);
    end
    idle(20);

    // Random traffic; the per-cycle compare covers every instance,
    // including the disabled one.
    for (int j = 0; j < 80; j++) begin
      step(4'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom));
      check($sformatf("t6_disabled_c%0d", j), {d_st[6], d_irq[6], 3'b000, d_irqo[6]}, 12'h000);
    end
    step(4'h0, 4'h0, 4'hF);
    idle(20);

`ifdef IRQ_GEN_MC_ERR_CNT_EN
    repeat (300) step(4'b0001, 4'h0, 4'h0);
    step(4'h0, 4'h0, 4'h0);
    check("t6_cnt_saturated", d_cnt[0][7:0], 8'hFF);
    step(4'h0, 4'h0, 4'b0001);
    step(4'h0, 4'h0, 4'h0);
    check("t6_cnt_cleared", d_cnt[0][7:0], 8'h00);
    idle(20);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
